// File: rtl/lc3b_types.sv
// Shared LC-3b cache types.
// Defines the word, line, tag, index and offset types used by the cache line controller and its
// line merge helper, plus a small word-extraction function.
package lc3b_types;

  localparam int unsigned TAG_W  = 10;
  localparam int unsigned LINE_W = 128;

  typedef logic [15:0]       lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [TAG_W-1:0]  lc3b_c_tag;
  typedef logic [1:0]        lc3b_c_index;
  typedef logic [3:0]        lc3b_c_offset;

  // Pick word 'sel' (0..7) out of a 128-bit line.
  function automatic lc3b_word line_word(input lc3b_line line, input logic [2:0] sel);
    lc3b_word word;
    word = '0;
    for (int w = 0; w < 8; w++) begin
      if (sel == w[2:0]) word = line[w*16 +: 16];
    end
    return word;
  endfunction

endpackage

// File: rtl/line_write_merge.sv
// Line write merge.
// Replaces the byte lanes of one 16-bit word inside a 128-bit line.
// Ports:
//   line        in  128  original line
//   word_sel    in  3    word offset within the line
//   byte_enable in  2    bit0 -> [7:0], bit1 -> [15:8] of the selected word
//   wdata       in  16   write word
//   merged      out 128  line with the selected lanes replaced
module line_write_merge
  import lc3b_types::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [2:0]        word_sel,
  input  logic [1:0]        byte_enable,
  input  logic [15:0]       wdata,
  output logic [LINE_W-1:0] merged
);

  always_comb begin
    merged = line;
    for (int w = 0; w < 8; w++) begin
      if (word_sel == w[2:0]) begin
        if (byte_enable[0]) merged[w*16 +: 8]     = wdata[7:0];
        if (byte_enable[1]) merged[w*16 + 8 +: 8] = wdata[15:8];
      end
    end
  end

endmodule

// File: rtl/cache_line_controller.sv
// Cache line controller.
// Direct-mapped, 4-line, write-back cache controller between the LC-3b CPU memory port and
// physical memory. Tags, valid and dirty bits live here; the line data lives in an external
// 4-entry array driven through data_write/data_index/data_in and read back on data_out.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_read/mem_write         CPU request, held until mem_resp (both high = write)
//   mem_byte_enable            CPU write byte lanes
//   mem_address/mem_wdata      CPU byte address and write word
//   mem_rdata/mem_resp         selected word and one-cycle completion pulse
//   pmem_read/pmem_write       line fill / writeback strobes to physical memory
//   pmem_address/pmem_wdata    line-aligned address and victim line
//   pmem_rdata/pmem_resp       fill line and physical memory completion
//   data_write/data_index      data array write enable and index (mem_address[5:4])
//   data_in/data_out           data array write line and combinational read line
module cache_line_controller
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_byte_enable,
  input  logic [15:0]   mem_address,
  input  logic [15:0]   mem_wdata,
  output logic [15:0]   mem_rdata,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp,
  output logic          data_write,
  output logic [1:0]    data_index,
  output logic [127:0]  data_in,
  input  logic [127:0]  data_out
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t       state;
  lc3b_c_tag    tags [4];
  logic [3:0]   valid;
  logic [3:0]   dirty;

  lc3b_c_index  idx;
  lc3b_c_tag    addr_tag;
  lc3b_c_offset offset;
  logic         req;
  logic         hit;
  lc3b_line     merged;
  logic         unused_byte_bit;

  assign idx             = mem_address[5:4];
  assign addr_tag        = mem_address[15:6];
  assign offset          = mem_address[3:0];
  assign unused_byte_bit = offset[0];
  assign req             = mem_read | mem_write;
  assign hit             = valid[idx] && (tags[idx] == addr_tag);

  line_write_merge u_merge (
    .line        (data_out),
    .word_sel    (offset[3:1]),
    .byte_enable (mem_byte_enable),
    .wdata       (mem_wdata),
    .merged      (merged)
  );

  assign data_index = idx;
  assign mem_rdata  = line_word(data_out, offset[3:1]);
  assign pmem_wdata = data_out;

  // Writeback targets the resident victim; fill targets the requested line.
  assign pmem_address = (state == WRITEBACK) ? {tags[idx], idx, 4'b0000}
                                             : {mem_address[15:4], 4'b0000};

  // Hits complete with zero wait states, so resp and array write are combinational.
  always_comb begin
    mem_resp   = 1'b0;
    data_write = 1'b0;
    data_in    = merged;
    if (state == IDLE && req && hit) begin
      mem_resp   = 1'b1;
      data_write = mem_write;
    end else if (state == FILL && pmem_resp) begin
      data_write = 1'b1;
      data_in    = pmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      for (int i = 0; i < 4; i++) tags[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (mem_write) dirty[idx] <= 1'b1;
          end else if (req) begin
            if (valid[idx] && dirty[idx]) begin
              state      <= WRITEBACK;
              pmem_write <= 1'b1;
            end else begin
              state     <= FILL;
              pmem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state      <= FILL;
            pmem_write <= 1'b0;
            pmem_read  <= 1'b1;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            tags[idx]  <= addr_tag;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_controller.sv
module tb_cache_line_controller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [1:0]   mem_byte_enable = 2'b00;
  logic [15:0]  mem_address = 16'h0;
  logic [15:0]  mem_wdata = 16'h0;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic         data_write;
  logic [1:0]   data_index;
  logic [127:0] data_in;
  logic [127:0] data_out;

  cache_line_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .data_write      (data_write),
    .data_index      (data_index),
    .data_in         (data_in),
    .data_out        (data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External line data array.
  logic [127:0] darr [4];
  initial for (int i = 0; i < 4; i++) darr[i] = '0;
  assign data_out = darr[data_index];
  always @(posedge clk) if (data_write) darr[data_index] <= data_in;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: flat word memory plus line residency of a 4-line direct-mapped cache.
  logic [15:0]  ref_mem [logic [14:0]];
  logic [127:0] pmem_store [logic [11:0]];
  bit   [3:0]   mvalid = '0;
  bit   [3:0]   mdirty = '0;
  logic [9:0]   mtag [4];

  function automatic logic [15:0] init_word(input logic [15:0] a);
    logic [15:0] t;
    if (a[15:1] == 15'h0020) return 16'h1234;
    t = {1'b0, a[15:1]};
    return (t * 16'h9e37) ^ 16'h3c96;
  endfunction

  function automatic logic [127:0] build_line(input logic [11:0] la);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = init_word({la, w[2:0], 1'b0});
    return l;
  endfunction

  function automatic logic [127:0] pmem_get(input logic [11:0] la);
    if (pmem_store.exists(la)) return pmem_store[la];
    return build_line(la);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a[15:1])) return ref_mem[a[15:1]];
    return init_word(a);
  endfunction

  function automatic logic [127:0] ref_line(input logic [11:0] la);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = ref_read({la, w[2:0], 1'b0});
    return l;
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
    logic [15:0] v;
    v = ref_read(a);
    if (be[0]) v[7:0] = d[7:0];
    if (be[1]) v[15:8] = d[15:8];
    ref_mem[a[15:1]] = v;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp_data;
    bit          check_data;
    bit          exp_hit;
    int          issue_cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
  } ptxn_t;
  ptxn_t plog[$];

  bit pmem_mute = 1'b0;

  // Physical memory responder with random latency.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (pmem_read || pmem_write) && !pmem_mute) begin
        int d;
        ptxn_t t;
        d = int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        if (rst_n && (pmem_read || pmem_write) && !pmem_mute) begin
          t.wr   = pmem_write;
          t.addr = pmem_address;
          if (pmem_write) begin
            t.data = pmem_wdata;
            pmem_store[pmem_address[15:4]] = pmem_wdata;
          end else begin
            t.data     = pmem_get(pmem_address[15:4]);
            pmem_rdata = t.data;
          end
          plog.push_back(t);
          pmem_resp = 1'b1;
          @(negedge clk);
          pmem_resp = 1'b0;
        end
      end
    end
  end

  // Strobe rules monitor.
  initial begin
    logic         prev_rd, prev_wr;
    logic [15:0]  prev_addr;
    logic [127:0] prev_wdata;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    prev_addr = '0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (pmem_read || pmem_write)) begin
        check("strobe_exclusive", pmem_read && pmem_write, 0);
        if ((pmem_read && prev_rd) || (pmem_write && prev_wr))
          check("pmem_addr_stable", pmem_address, prev_addr);
        if (pmem_write && prev_wr) check("pmem_wdata_stable", pmem_wdata, prev_wdata);
      end
      prev_rd = rst_n && pmem_read;
      prev_wr = rst_n && pmem_write;
      prev_addr = pmem_address;
      prev_wdata = pmem_wdata;
    end
  end

  // Response monitor: pops the scoreboard on each mem_resp.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_resp) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", mem_resp, 0);
        end else begin
          sb_t e;
          int lat;
          e = sb.pop_front();
          lat = cyc - e.issue_cyc;
          if (e.check_data) check("rdata", mem_rdata, e.exp_data);
          check(e.exp_hit ? "hit_latency" : "miss_latency",
                e.exp_hit ? (lat == 0) : (lat >= 2), 1);
        end
      end
    end
  end

  // Issue one CPU access (called just after a rising edge) and wait for its completion.
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [1:0] be, input logic [15:0] wdata);
    logic [1:0]   idx;
    logic [9:0]   tag;
    bit           hit, wb, got;
    logic [15:0]  wb_addr;
    logic [127:0] wb_line;
    sb_t          e;
    int           waited, exp_n, i;
    idx = addr[5:4];
    tag = addr[15:6];
    hit = mvalid[idx] && (mtag[idx] == tag);
    wb  = !hit && mvalid[idx] && mdirty[idx];
    wb_addr = {mtag[idx], idx, 4'h0};
    wb_line = ref_line(wb_addr[15:4]);
    e.addr = addr;
    e.exp_data = ref_read(addr);
    e.check_data = !wr;
    e.exp_hit = hit;
    e.issue_cyc = cyc;
    plog.delete();
    sb.push_back(e);
    mem_read = rd;
    mem_write = wr;
    mem_address = addr;
    mem_byte_enable = be;
    mem_wdata = wdata;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 100) begin
      @(negedge clk);
      if (mem_resp) got = 1'b1;
      else waited++;
    end
    check("resp_timeout", got, 1);
    if (!got) sb.delete();
    if (wr) ref_write(addr, be, wdata);
    mdirty[idx] = (hit && mdirty[idx]) || wr;
    mvalid[idx] = 1'b1;
    mtag[idx] = tag;
    exp_n = (hit ? 0 : 1) + (wb ? 1 : 0);
    check("pmem_txn_count", plog.size(), exp_n);
    if (plog.size() == exp_n && !hit) begin
      i = 0;
      if (wb) begin
        check("wb_is_write", plog[0].wr, 1);
        check("wb_addr", plog[0].addr, wb_addr);
        check("wb_line", plog[0].data, wb_line);
        i = 1;
      end
      check("fill_is_read", plog[i].wr, 0);
      check("fill_addr", plog[i].addr, {addr[15:4], 4'h0});
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w42;
    for (int i = 0; i < 4; i++) mtag[i] = '0;
    // Reset state, with a request already presented.
    mem_read = 1'b1;
    mem_address = 16'h0040;
    #23;
    check("rst_mem_resp", mem_resp, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_data_write", data_write, 0);
    mem_read = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold read, repeat read, write hit with lane merge, conflicting read with writeback.
    access(1, 0, 16'h0040, 2'b00, 16'h0);
    access(1, 0, 16'h0040, 2'b00, 16'h0);
    w42 = init_word(16'h0042);
    fork
      access(0, 1, 16'h0042, 2'b10, 16'hAB00);
      begin
        @(negedge clk);
        check("wr_hit_data_write", data_write, 1);
        check("wr_hit_word1", data_in[31:16], {8'hAB, w42[7:0]});
        check("wr_hit_word0", data_in[15:0], 16'h1234);
      end
    join
    access(1, 0, 16'h0440, 2'b00, 16'h0);

    // Reset during a fill that never gets a pmem_resp.
    pmem_mute = 1'b1;
    mem_read = 1'b1;
    mem_address = 16'h0040;
    repeat (3) @(negedge clk);
    check("mid_fill_pmem_read", pmem_read, 1);
    check("mid_fill_pmem_addr", pmem_address, 16'h0040);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pmem_read", pmem_read, 0);
    check("mid_rst_pmem_write", pmem_write, 0);
    check("mid_rst_data_write", data_write, 0);
    check("mid_rst_mem_resp", mem_resp, 0);
    mem_read = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    pmem_mute = 1'b0;
    mvalid = '0;
    mdirty = '0;
    @(posedge clk);
    #1;
    access(1, 0, 16'h0440, 2'b00, 16'h0);
    access(1, 0, 16'h0040, 2'b00, 16'h0);

    // Read and write together on a hit is a write; the later eviction proves dirty was set.
    access(1, 0, 16'h0060, 2'b00, 16'h0);
    access(1, 1, 16'h0062, 2'b01, 16'h00CD);
    access(1, 0, 16'h0062, 2'b00, 16'h0);
    access(1, 0, 16'h0460, 2'b00, 16'h0);

    // Randomized traffic over a small tag pool so lines conflict often.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      logic [9:0]  t;
      int          op;
      t = 10'(37 * $urandom_range(0, 3));
      a = {t, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b0};
      op = int'($urandom_range(0, 2));
      access(op != 1, op != 0, a, 2'($urandom_range(0, 3)), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
